// File: rtl/control_path_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpuConfig (package)
//  Description : Shared encodings for the picoMIPS control path: opcodes,
//                ALU function select and controller states, plus a small
//                decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpuConfig;

  localparam int OPCODE_W = 6;

  // Opcodes are prefixed OP_ so that OP_HALT does not collide with the
  // HALT controller state below.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP    = 6'd0,
    OP_ADD    = 6'd1,
    OP_ADDI   = 6'd2,
    OP_SUB    = 6'd3,
    OP_SUBI   = 6'd4,
    OP_MUL    = 6'd5,
    OP_MULI   = 6'd6,
    OP_LDSW   = 6'd7,
    OP_BEQ    = 6'd8,
    OP_BNE    = 6'd9,
    OP_JMP    = 6'd10,
    OP_CALL   = 6'd11,
    OP_RET    = 6'd12,
    OP_WAITSW = 6'd13,
    OP_HALT   = 6'd63
  } opCode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    PASS_B  = 2'd3
  } aluFunc_t;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    HALT         = 2'd3
  } ctrlState_t;

  // Opcodes that write a general-purpose register (ALU ops and LDSW).
  function automatic logic writesReg(input logic [OPCODE_W-1:0] op);
    return op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI, OP_LDSW};
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_path_seq_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : LIFO of return addresses for CALL/RET. Contents are not
//                reset; only the stack pointer is.
//  Ports       : clk, nReset     - clock, async active-low reset
//                push_i / pop_i  - push dataIn_i / drop top entry
//                dataIn_i        - address to push
//                dataOut_o       - current top entry (valid when !empty_o)
//                full_o, empty_o - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int P_SIZE      = 5
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [P_SIZE-1:0] dataIn_i,
  output logic [P_SIZE-1:0] dataOut_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  // Storage index width; kept at least 1 so a depth-1 stack still has a
  // legal index.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [P_SIZE-1:0] mem_q [2**IDX_W];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [SP_W-1:0]   spDec;

  assign spDec     = sp_q - SP_W'(1);
  assign full_o    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o   = (sp_q == '0);
  assign dataOut_o = mem_q[spDec[IDX_W-1:0]];

  // Push and pop are mutually exclusive in the controller; push wins if both.
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = spDec;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[IDX_W-1:0]] <= dataIn_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_path_seq.sv
`default_nettype none
// ============================================================================
//  Module      : control_path_seq
//  Description : picoMIPS control path. Sequences the program counter
//                through branches, jumps, CALL/RET, a switch handshake and
//                a terminal HALT, and decodes datapath control fields.
//  Ports       : clk, nReset        - clock, async active-low reset
//                pcOut              - program memory address
//                instructionIn      - {opCode, opD, opS} for pcOut
//                aluZero            - ALU zero result of current instruction
//                switchesIn         - board switches, bit 8 = handshake
//                aluFunc, aluImmediate, immSwitches, regWrite - datapath ctrl
//                opD, opS           - instruction operand fields
//                halted, stackError - status
//                displayOpCode      - current opcode for the demo display
//  Revision    : 1.0 - initial release
// ============================================================================
module control_path_seq
  import cpuConfig::*;
#(
  parameter int N           = 8,
  parameter int O_SIZE      = 6,
  parameter int P_SIZE      = 5,
  parameter int R_SIZE      = 3,
  parameter int I_SIZE      = O_SIZE + R_SIZE + N,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nReset,
  output logic [P_SIZE-1:0] pcOut,
  input  logic [I_SIZE-1:0] instructionIn,
  input  logic              aluZero,
  input  logic [9:0]        switchesIn,
  output aluFunc_t          aluFunc,
  output logic              aluImmediate,
  output logic              immSwitches,
  output logic              regWrite,
  output logic [R_SIZE-1:0] opD,
  output logic [N-1:0]      opS,
  output logic              halted,
  output logic              stackError,
  output logic [O_SIZE-1:0] displayOpCode
);

  ctrlState_t        state_q, state_d;
  logic [P_SIZE-1:0] pc_q, pc_d;
  logic              zFlag_q, zFlag_d;
  logic              stackError_q, stackError_d;
  logic              sync1_q, sync2_q;

  logic [O_SIZE-1:0] opCode;
  logic [P_SIZE-1:0] pcInc;
  logic [P_SIZE-1:0] target;
  logic              swSync;
  logic              push, pop;
  logic [P_SIZE-1:0] stkTop;
  logic              stkFull, stkEmpty;
  logic              wrDec;

  // The low switch byte and bit 9 belong to the datapath, not this block.
  logic unused_sw;
  assign unused_sw = ^{switchesIn[9], switchesIn[7:0]};

  assign opCode        = instructionIn[I_SIZE-1 -: O_SIZE];
  assign opD           = instructionIn[N +: R_SIZE];
  assign opS           = instructionIn[N-1:0];
  assign displayOpCode = opCode;
  assign pcInc         = pc_q + P_SIZE'(1);
  assign target        = instructionIn[P_SIZE-1:0];
  assign swSync        = sync2_q;

  assign pcOut      = pc_q;
  assign halted     = (state_q == HALT);
  assign stackError = stackError_q;
  // Gated by nReset so no write strobe escapes while reset is held.
  assign regWrite   = wrDec && (state_q == RUN) && nReset;

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .P_SIZE     (P_SIZE)
  ) u_return_stack (
    .clk      (clk),
    .nReset   (nReset),
    .push_i   (push),
    .pop_i    (pop),
    .dataIn_i (pcInc),
    .dataOut_o(stkTop),
    .full_o   (stkFull),
    .empty_o  (stkEmpty)
  );

  // Datapath control decode: purely a function of the opcode.
  always_comb begin
    aluFunc      = ALU_ADD;
    aluImmediate = 1'b0;
    immSwitches  = 1'b0;
    wrDec        = writesReg(opCode);
    case (opCode)
      OP_ADDI:         aluImmediate = 1'b1;
      OP_SUB:          aluFunc = ALU_SUB;
      OP_SUBI: begin
        aluFunc      = ALU_SUB;
        aluImmediate = 1'b1;
      end
      OP_MUL:          aluFunc = ALU_MUL;
      OP_MULI: begin
        aluFunc      = ALU_MUL;
        aluImmediate = 1'b1;
      end
      OP_LDSW: begin
        aluFunc      = PASS_B;
        aluImmediate = 1'b1;
        immSwitches  = 1'b1;
      end
      default:         aluFunc = ALU_ADD;
    endcase
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    zFlag_d      = zFlag_q;
    stackError_d = stackError_q;
    push         = 1'b0;
    pop          = 1'b0;
    case (state_q)
      RUN: begin
        case (opCode)
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI: begin
            zFlag_d = aluZero;
            pc_d    = pcInc;
          end
          // Branches see the flag as it stood before this edge.
          OP_BEQ: pc_d = zFlag_q ? target : pcInc;
          OP_BNE: pc_d = zFlag_q ? pcInc : target;
          OP_JMP: pc_d = target;
          OP_CALL: begin
            if (stkFull) begin
              stackError_d = 1'b1;
              state_d      = HALT;
            end else begin
              push = 1'b1;
              pc_d = target;
            end
          end
          OP_RET: begin
            if (stkEmpty) begin
              stackError_d = 1'b1;
              state_d      = HALT;
            end else begin
              pop  = 1'b1;
              pc_d = stkTop;
            end
          end
          OP_WAITSW: state_d = WAIT_PRESS;
          OP_HALT:   state_d = HALT;
          default:   pc_d = pcInc;  // NOP, LDSW, unknown
        endcase
      end
      WAIT_PRESS: begin
        if (swSync) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!swSync) begin
          state_d = RUN;
          pc_d    = pcInc;
        end
      end
      default: state_d = state_q;  // HALT is absorbing
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= RUN;
      pc_q         <= '0;
      zFlag_q      <= 1'b0;
      stackError_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      zFlag_q      <= zFlag_d;
      stackError_q <= stackError_d;
      sync1_q      <= switchesIn[8];
      sync2_q      <= sync1_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_path_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_path_seq
//  Description : Self-checking bench for control_path_seq: directed vector
//                table, hand-written multi-cycle sequences, and a random run
//                against a behavioural model of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_path_seq;
  import cpuConfig::*;

  localparam int N = 8, O_SIZE = 6, P_SIZE = 5, R_SIZE = 3;
  localparam int I_SIZE = O_SIZE + R_SIZE + N;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              nReset;
  logic [P_SIZE-1:0] pcOut;
  logic [I_SIZE-1:0] instructionIn;
  logic              aluZero;
  logic [9:0]        switchesIn;
  aluFunc_t          aluFunc;
  logic              aluImmediate, immSwitches, regWrite;
  logic [R_SIZE-1:0] opD;
  logic [N-1:0]      opS;
  logic              halted, stackError;
  logic [O_SIZE-1:0] displayOpCode;

  always #5 clk = ~clk;

  control_path_seq #(
    .N(N), .O_SIZE(O_SIZE), .P_SIZE(P_SIZE), .R_SIZE(R_SIZE),
    .I_SIZE(I_SIZE), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .nReset(nReset), .pcOut(pcOut), .instructionIn(instructionIn),
    .aluZero(aluZero), .switchesIn(switchesIn), .aluFunc(aluFunc),
    .aluImmediate(aluImmediate), .immSwitches(immSwitches), .regWrite(regWrite),
    .opD(opD), .opS(opS), .halted(halted), .stackError(stackError),
    .displayOpCode(displayOpCode)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [7:0] s, input logic az, input logic sw);
    instructionIn = {op, s[2:0] ^ 3'd5, s};
    aluZero       = az;
    switchesIn    = {1'b0, sw, 8'hA5};
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2-3 time units
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    drive(OP_NOP, 8'd0, 1'b0, 1'b0);
    tick();
    nReset = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_RUN = 0, M_PRESS = 1, M_REL = 2, M_HALT = 3;
  int m_pc, m_mode;
  bit m_z, m_err, m_s1, m_s2;
  int m_stk[$];

  task automatic model_reset();
    m_pc = 0; m_mode = M_RUN; m_z = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
    m_stk.delete();
  endtask

  task automatic model_edge(input int op, input int s, input bit az, input bit sw);
    int nxt;
    nxt = (m_pc + 1) % 32;
    case (m_mode)
      M_RUN: begin
        if (op >= 1 && op <= 6) begin m_z = az; m_pc = nxt; end
        else if (op == 8)  m_pc = m_z ? s % 32 : nxt;
        else if (op == 9)  m_pc = m_z ? nxt : s % 32;
        else if (op == 10) m_pc = s % 32;
        else if (op == 11) begin
          if (m_stk.size() == DEPTH) begin m_err = 1; m_mode = M_HALT; end
          else begin m_stk.push_back(nxt); m_pc = s % 32; end
        end else if (op == 12) begin
          if (m_stk.size() == 0) begin m_err = 1; m_mode = M_HALT; end
          else m_pc = m_stk.pop_back();
        end
        else if (op == 13) m_mode = M_PRESS;
        else if (op == 63) m_mode = M_HALT;
        else m_pc = nxt;
      end
      M_PRESS: if (m_s2) m_mode = M_REL;
      M_REL:   if (!m_s2) begin m_mode = M_RUN; m_pc = nxt; end
      default: ;
    endcase
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] op;
    logic [7:0] s;
    logic       az;
    logic [4:0] pc;
    logic       rw;
  } vec_t;
  vec_t tbl[16];

  int t_call[4] = '{8, 16, 24, 4};
  int t_ret[4]  = '{25, 17, 9, 1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{OP_ADD,  8'h00, 1'b0, 5'd0,  1'b1};
    tbl[1]  = '{OP_ADDI, 8'h05, 1'b0, 5'd1,  1'b1};
    tbl[2]  = '{OP_SUB,  8'h00, 1'b1, 5'd2,  1'b1};
    tbl[3]  = '{OP_BEQ,  8'hE9, 1'b0, 5'd3,  1'b0};  // taken to 9
    tbl[4]  = '{OP_NOP,  8'h00, 1'b0, 5'd9,  1'b0};
    tbl[5]  = '{OP_SUB,  8'h00, 1'b0, 5'd10, 1'b1};
    tbl[6]  = '{OP_BEQ,  8'h14, 1'b0, 5'd11, 1'b0};  // not taken
    tbl[7]  = '{OP_SUB,  8'h00, 1'b1, 5'd12, 1'b1};
    tbl[8]  = '{OP_BNE,  8'h03, 1'b0, 5'd13, 1'b0};  // not taken
    tbl[9]  = '{OP_SUB,  8'h00, 1'b0, 5'd14, 1'b1};
    tbl[10] = '{OP_BNE,  8'h3E, 1'b0, 5'd15, 1'b0};  // taken to 30
    tbl[11] = '{OP_LDSW, 8'h00, 1'b0, 5'd30, 1'b1};
    tbl[12] = '{OP_JMP,  8'h1F, 1'b0, 5'd31, 1'b0};  // tight loop
    tbl[13] = '{OP_JMP,  8'h1F, 1'b0, 5'd31, 1'b0};
    tbl[14] = '{OP_NOP,  8'h00, 1'b0, 5'd31, 1'b0};  // wraps
    tbl[15] = '{OP_NOP,  8'h00, 1'b0, 5'd0,  1'b0};

    // Reset state, with a register-writing opcode presented.
    nReset = 1'b1;
    drive(OP_ADD, 8'd0, 1'b0, 1'b0);
    #2 nReset = 1'b0;
    #1;
    chk("reset_pc", pcOut, 0);
    chk("reset_regWrite", regWrite, 0);
    chk("reset_halted", halted, 0);
    chk("reset_stackError", stackError, 0);
    tick();
    nReset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].op, tbl[i].s, tbl[i].az, 1'b0);
      #1;
      chk($sformatf("tbl%0d_pc", i), pcOut, tbl[i].pc);
      chk($sformatf("tbl%0d_regWrite", i), regWrite, tbl[i].rw);
      chk($sformatf("tbl%0d_opS", i), opS, tbl[i].s);
      if (tbl[i].op == OP_LDSW) begin
        chk("ldsw_aluFunc", aluFunc, PASS_B);
        chk("ldsw_aluImmediate", aluImmediate, 1);
        chk("ldsw_immSwitches", immSwitches, 1);
        chk("ldsw_switch_byte", switchesIn[7:0], 8'hA5);
      end
      tick();
    end

    // Nested CALLs, RETs, overflow.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(OP_CALL, 8'(t_call[k]), 1'b0, 1'b0);
      #1 chk($sformatf("call%0d_site", k), pcOut, (k == 0) ? 0 : t_call[k-1]);
      tick();
    end
    #1 chk("call_depth4_pc", pcOut, 4);
    for (int k = 0; k < 4; k++) begin
      drive(OP_RET, 8'd0, 1'b0, 1'b0);
      tick();
      #1 chk($sformatf("ret%0d_pc", k), pcOut, t_ret[k]);
    end
    chk("ret_no_error", stackError, 0);
    for (int k = 0; k < 4; k++) begin
      drive(OP_CALL, 8'(t_call[k]), 1'b0, 1'b0);
      tick();
    end
    drive(OP_CALL, 8'd12, 1'b0, 1'b0);
    tick();
    #1;
    chk("overflow_halted", halted, 1);
    chk("overflow_stackError", stackError, 1);
    chk("overflow_pc", pcOut, 4);
    drive(OP_ADD, 8'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk("halt_regWrite", regWrite, 0);
    chk("halt_pc_frozen", pcOut, 4);
    // Asynchronous reset out of HALT.
    nReset = 1'b0;
    #1;
    chk("halt_async_rst_pc", pcOut, 0);
    chk("halt_async_rst_halted", halted, 0);
    chk("halt_async_rst_err", stackError, 0);
    tick();
    nReset = 1'b1;
    drive(OP_RET, 8'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk("underflow_halted", halted, 1);
    chk("underflow_stackError", stackError, 1);
    chk("underflow_pc", pcOut, 0);

    // WAITSW handshake at pc 5: switch high on cycles 10..19.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(OP_NOP, 8'd0, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 24; c++) begin
      int exp_pc;
      exp_pc = (c <= 22) ? 5 : 6;
      drive((exp_pc == 5) ? OP_WAITSW : OP_NOP, 8'd0, 1'b0, (c >= 10 && c < 20));
      #1;
      chk($sformatf("wait_c%0d_pc", c), pcOut, exp_pc);
      chk($sformatf("wait_c%0d_regWrite", c), regWrite, 0);
      tick();
    end
    #1 chk("wait_exit_pc", pcOut, 7);
    // Asynchronous reset while in WAIT_PRESS.
    for (int k = 0; k < 3; k++) begin
      drive(OP_WAITSW, 8'd0, 1'b0, 1'b0);
      tick();
    end
    drive(OP_ADD, 8'd0, 1'b0, 1'b0);
    #1 chk("wait_press_held", pcOut, 7);
    chk("wait_press_regWrite", regWrite, 0);
    nReset = 1'b0;
    #1 chk("wait_async_rst_pc", pcOut, 0);
    tick();
    nReset = 1'b1;
    #1 chk("after_wait_rst_regWrite", regWrite, 1);
    tick();
    #1 chk("after_wait_rst_pc", pcOut, 1);

    // Random run against the reference model.
    begin
      bit swl;
      int halt_cnt;
      swl = 0;
      halt_cnt = 0;
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        int r, op, s;
        bit az;
        if (m_mode == M_HALT && halt_cnt >= 2) begin
          nReset = 1'b0;
          #1 chk("rnd_async_rst_pc", pcOut, 0);
          model_reset();
          halt_cnt = 0;
          tick();
          nReset = 1'b1;
        end
        r = $urandom_range(0, 99);
        if (r < 30)      op = $urandom_range(1, 6);
        else if (r < 35) op = 7;
        else if (r < 45) op = 8;
        else if (r < 55) op = 9;
        else if (r < 60) op = 10;
        else if (r < 72) op = 11;
        else if (r < 82) op = 12;
        else if (r < 88) op = 13;
        else if (r < 90) op = 63;
        else if (r < 95) op = 0;
        else             op = $urandom_range(14, 62);
        s  = $urandom_range(0, 255);
        az = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) swl = ~swl;
        drive(6'(op), 8'(s), az, swl);
        #1;
        chk("rnd_pc", pcOut, m_pc);
        chk("rnd_halted", halted, m_mode == M_HALT);
        chk("rnd_stackError", stackError, m_err);
        chk("rnd_regWrite", regWrite, (m_mode == M_RUN) && op >= 1 && op <= 7);
        chk("rnd_opS", opS, s);
        chk("rnd_opD", opD, (s % 8) ^ 5);
        chk("rnd_displayOpCode", displayOpCode, op);
        if (op >= 1 && op <= 7) begin
          chk("rnd_aluFunc", aluFunc,
              (op <= 2) ? ALU_ADD : (op <= 4) ? ALU_SUB : (op <= 6) ? ALU_MUL : PASS_B);
          chk("rnd_aluImmediate", aluImmediate, (op % 2 == 0) || op == 7);
          chk("rnd_immSwitches", immSwitches, op == 7);
        end
        tick();
        model_edge(op, s, az, swl);
        if (m_mode == M_HALT) halt_cnt++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_path_seq.md
Name: control_path_seq

Overview:
- Next-generation picoMIPS control path, replacing the single-cycle PC-increment controller.
- Adds conditional branches on a registered zero flag, jumps, CALL/RET with a parametrised return stack, a switch-wait handshake (WAITSW), and a terminal HALT state.
- Drives the external combinational program memory address and the datapath control/operand fields.
- Instantiated by the CPU top beside the datapath.

Parameters:
- N, 8, data bus / immediate width
- O_SIZE, 6, opcode width
- P_SIZE, 5, program memory address width
- R_SIZE, 3, GPR address width
- I_SIZE, O_SIZE+R_SIZE+N, instruction width
- STACK_DEPTH, 4, return stack entries (>=1)

Ports:
- clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- pcOut  out  P_SIZE  program memory address
- instructionIn  in  I_SIZE  {opCode, opD, opS} from program memory, valid in the same cycle as pcOut
- aluZero  in  1  datapath ALU zero result for the current instruction
- switchesIn  in  10  raw board switches; bit 8 is the handshake switch
- aluFunc  out  cpuConfig::aluFunc_t  ALU operation
- aluImmediate  out  1  ALU B operand is opS
- immSwitches  out  1  ALU B operand is switchesIn[7:0]
- regWrite  out  1  GPR write enable
- opD  out  R_SIZE  destination register field
- opS  out  N  source register / immediate field
- halted  out  1  controller is in HALT
- stackError  out  1  sticky; set on overflow or underflow
- displayOpCode  out  O_SIZE  current opcode, for the demo display

Behaviour:
- Reset (asynchronous): pc=0, state=RUN, sp=0, zFlag=0, sync flops=0, stackError=0.
- While nReset is low: regWrite=0, halted=0, pcOut=0.
- Reset asserted in any state, including mid-WAIT, returns to RUN at pc=0.
- switchesIn[8] passes through a 2-flop synchroniser to swSync; this adds 2 cycles of latency.
- opD and opS are always passed straight through from instructionIn. Control outputs are combinational from opCode and state.
- States and transitions:
  - RUN: executes one instruction per cycle.
  - WAIT_PRESS: on swSync=1, go to WAIT_RELEASE.
  - WAIT_RELEASE: on swSync=0, go to RUN with pc+1.
  - HALT: absorbing; only reset exits.
- In WAIT_* and HALT: regWrite=0 and pc is held.
- RUN, ALU ops (ADD, ADDI, SUB, SUBI, MUL, MULI): regWrite=1, pc+1. zFlag<=aluZero at the clock edge.
- RUN, LDSW: aluFunc=PASS_B, aluImmediate=1, immSwitches=1, regWrite=1, pc+1. zFlag is unchanged.
- RUN, BEQ / BNE: if zFlag==1 (BEQ) or zFlag==0 (BNE), pc<=opS[P_SIZE-1:0]; otherwise pc+1. No register write.
- RUN, JMP: pc<=opS[P_SIZE-1:0].
- RUN, CALL:
  - Stack not full: push (pc+1) mod 2^P_SIZE, sp++, pc<=target.
  - Stack full (sp==STACK_DEPTH): no push, stackError<=1, go to HALT.
- RUN, RET:
  - sp>0: sp--, pc<=stack[sp-1].
  - sp==0: stackError<=1, go to HALT.
- RUN, WAITSW: go to WAIT_PRESS, pc held. If the switch is already high, the bench sees WAIT_PRESS for one cycle and then moves to WAIT_RELEASE.
- RUN, HALT: go to HALT, pc held.
- RUN, NOP or unknown opcode: pc+1, no write.
- pc+1 wraps from 2^P_SIZE-1 to 0. A branch target equal to the current pc is legal and gives a tight loop.
- Simultaneous events: a branch uses zFlag as registered before the current edge. An ALU op immediately before a branch is visible to that branch.
- sp width: $clog2(STACK_DEPTH+1).
- Stack contents are not reset; only sp is reset.
- halted=1 exactly when state==HALT.

Decomposition:
- cpuConfig package holds:
  - opCode_t enum with fixed encodings: NOP=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, MULI=6, LDSW=7, BEQ=8, BNE=9, JMP=10, CALL=11, RET=12, WAITSW=13, HALT=63.
  - aluFunc_t, including PASS_B.
  - ctrlState_t enum {RUN, WAIT_PRESS, WAIT_RELEASE, HALT}.
- One sub-module: return_stack (parameters STACK_DEPTH, P_SIZE).
  - Inputs: push, pop, dataIn.
  - Outputs: dataOut, full, empty.
  - clk and nReset.
- Decode logic stays inline.

Test Plan:
- Reset then run ADD, ADDI, NOP from pc 0 -> pcOut 0,1,2,3 on successive edges; regWrite high only for the ADD and ADDI cycles.
- SUB with aluZero=1 at pc 2, then BEQ target 9 at pc 3 -> pcOut=9. Repeat with aluZero=0 -> pcOut=4. Repeat both cases with BNE -> opposite outcomes.
- Nested CALLs to depth 4, then RET x4 -> pc returns to each call site +1. A 5th nested CALL -> halted=1, stackError=1, pc frozen. RET on empty stack after reset -> the same.
- WAITSW at pc 5, switch raised at cycle 10 and dropped at cycle 20 -> pc held at 5 until 2 cycles after the drop, then 6; regWrite=0 throughout.
- LDSW with switchesIn[7:0]=0xA5 -> immSwitches=1, aluImmediate=1, aluFunc=PASS_B, regWrite=1.
- JMP at pc 31 (P_SIZE=5) to 31 -> holds at 31. NOP at pc 31 -> wraps to 0.
- nReset pulsed low while in WAIT_PRESS and again while in HALT -> pcOut=0 immediately (asynchronous), state RUN, stackError cleared.
